// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the multi-cycle adder/subtractor.
// The master issues operations and the slave (the arithmetic core) reports status and results.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, m, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, m, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, with the carry/borrow held in a register.
// The result, carry_out and overflow outputs are sticky and are updated only on the done cycle.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one chunk is added per cycle; the last chunk loads the outputs
module serial_add_sub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_sub_if.slave bus
);
  localparam int N    = WIDTH / BITS_PER_CYCLE;
  localparam int BPC  = BITS_PER_CYCLE;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             load, step, finish;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             m_q, carry_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q, cout_q, ovf_q;
  logic [WIDTH-1:0] result_q;

  logic [BPC-1:0]   a_chunk, b_eff;
  logic [BPC:0]     sum_ext;
  logic [BPC-1:0]   sum_chunk;
  logic             c_msb_in;
  logic [WIDTH-1:0] acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state_q)
      IDLE: load = bus.start;
      RUN: begin
        step   = 1'b1;
        finish = (cnt_q == LAST);
      end
      default: ;
    endcase
  end

  // Subtraction computes a + ~b + 1; the +1 enters as the initial carry.
  assign a_chunk   = a_sh[BPC-1:0];
  assign b_eff     = b_sh[BPC-1:0] ^ {BPC{m_q}};
  assign sum_ext   = {1'b0, a_chunk} + {1'b0, b_eff} + {{BPC{1'b0}}, carry_q};
  assign sum_chunk = sum_ext[BPC-1:0];
  assign c_msb_in  = sum_chunk[BPC-1] ^ a_chunk[BPC-1] ^ b_eff[BPC-1];

  // The accumulator holds only the chunks already completed; the current chunk is appended on top.
  generate
    if (N == 1) begin : g_one
      assign acc_d = sum_chunk;
    end else begin : g_multi
      logic [WIDTH-BPC-1:0] acc_q, acc_nx;
      if (N == 2) begin : g_two
        assign acc_nx = sum_chunk;
      end else begin : g_many
        assign acc_nx = {sum_chunk, acc_q[WIDTH-BPC-1:BPC]};
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    acc_q <= '0;
        else if (load) acc_q <= '0;
        else if (step) acc_q <= acc_nx;
      end
      assign acc_d = {sum_chunk, acc_q};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      a_sh    <= bus.a;
      b_sh    <= bus.b;
      m_q     <= bus.m;
      carry_q <= bus.m;
      cnt_q   <= '0;
    end else if (step) begin
      a_sh    <= a_sh >> BPC;
      b_sh    <= b_sh >> BPC;
      carry_q <= sum_ext[BPC];
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        result_q <= acc_d;
        cout_q   <= sum_ext[BPC] ^ m_q;
        ovf_q    <= c_msb_in ^ sum_ext[BPC];
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: four parameterisations, with expected results queued at start and popped on done.
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(8))  if8 ();
  serial_add_sub_if #(.WIDTH(16)) if16a ();
  serial_add_sub_if #(.WIDTH(16)) if16b ();
  serial_add_sub_if #(.WIDTH(4))  if4 ();

  serial_add_sub #(.WIDTH(8),  .BITS_PER_CYCLE(1))  u8   (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_add_sub #(.WIDTH(16), .BITS_PER_CYCLE(4))  u16a (.clk(clk), .rst_n(rst_n), .bus(if16a));
  serial_add_sub #(.WIDTH(16), .BITS_PER_CYCLE(16)) u16b (.clk(clk), .rst_n(rst_n), .bus(if16b));
  serial_add_sub #(.WIDTH(4),  .BITS_PER_CYCLE(2))  u4   (.clk(clk), .rst_n(rst_n), .bus(if4));

  localparam int W  [4] = '{8, 16, 16, 4};
  localparam int NL [4] = '{8, 4, 1, 2};

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } obs_t;

  typedef struct {
    int          inst;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b, input logic m,
                                output logic [15:0] res, output logic cout, output logic ovf);
    logic [31:0] mask, aa, bb, full;
    mask = (32'd1 << w) - 32'd1;
    aa   = {16'd0, a} & mask;
    bb   = {16'd0, b} & mask;
    if (!m) begin
      full = aa + bb;
      cout = full[w];
    end else begin
      full = aa - bb;
      cout = (aa < bb);
    end
    res = full[15:0] & mask[15:0];
    ovf = (m ? (aa[w-1] != bb[w-1]) : (aa[w-1] == bb[w-1])) && (res[w-1] != aa[w-1]);
  endfunction

  task automatic drive(input int inst, input logic st, input logic [15:0] a, input logic [15:0] b, input logic m);
    case (inst)
      0: begin if8.start = st;   if8.a = a[7:0];   if8.b = b[7:0];   if8.m = m;   end
      1: begin if16a.start = st; if16a.a = a;      if16a.b = b;      if16a.m = m; end
      2: begin if16b.start = st; if16b.a = a;      if16b.b = b;      if16b.m = m; end
      default: begin if4.start = st; if4.a = a[3:0]; if4.b = b[3:0]; if4.m = m; end
    endcase
  endtask

  function automatic obs_t obs(input int inst);
    obs_t o;
    case (inst)
      0: o = '{if8.busy, if8.done, {8'd0, if8.result}, if8.carry_out, if8.overflow};
      1: o = '{if16a.busy, if16a.done, if16a.result, if16a.carry_out, if16a.overflow};
      2: o = '{if16b.busy, if16b.done, if16b.result, if16b.carry_out, if16b.overflow};
      default: o = '{if4.busy, if4.done, {12'd0, if4.result}, if4.carry_out, if4.overflow};
    endcase
    return o;
  endfunction

  // Call at a falling edge; returns at the falling edge just after the accepting rising edge.
  task automatic start_op(input int inst, input logic [15:0] a, input logic [15:0] b, input logic m);
    exp_t e;
    e.inst = inst;
    model(W[inst], a, b, m, e.res, e.cout, e.ovf);
    sb.push_back(e);
    drive(inst, 1'b1, a, b, m);
    @(negedge clk);
    drive(inst, 1'b0, a, b, m);
  endtask

  task automatic check_done(input int inst, input string name, input int exp_lat, input int exp_busy);
    int   cyc = 0;
    int   bcnt = 0;
    obs_t o;
    exp_t e;
    o = obs(inst);
    while (!o.done && cyc < 40) begin
      if (o.busy) bcnt++;
      @(negedge clk);
      cyc++;
      o = obs(inst);
    end
    checks++;
    if (o.done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles", name, o.done, cyc);
    end
    checks++;
    if (cyc !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
    end
    checks++;
    if (o.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b want 0", name, o.busy);
    end
    if (exp_busy >= 0) begin
      checks++;
      if (bcnt !== exp_busy) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d want %0d", name, bcnt, exp_busy);
      end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty want entry", name);
    end else begin
      e = sb.pop_front();
      if (o.res !== e.res) begin
        errors++;
        $display("FAIL %s result: got %h want %h", name, o.res, e.res);
      end
      checks++;
      if (o.cout !== e.cout) begin
        errors++;
        $display("FAIL %s carry_out: got %b want %b", name, o.cout, e.cout);
      end
      checks++;
      if (o.ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s overflow: got %b want %b", name, o.ovf, e.ovf);
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      o = obs(i);
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got %h want 0", i, o);
      end
    end
  endtask

  task automatic test_add();
    obs_t o;
    start_op(0, 16'h05, 16'h03, 1'b0);
    check_done(0, "add_05_03", 8, 8);
    @(negedge clk);
    o = obs(0);
    checks++;
    if (o.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got %b want 0", o.done);
    end
    start_op(0, 16'hFF, 16'h01, 1'b0);
    check_done(0, "add_FF_01", 8, 8);
    start_op(0, 16'h7F, 16'h01, 1'b0);
    check_done(0, "add_7F_01", 8, 8);
  endtask

  task automatic test_sub();
    start_op(0, 16'h03, 16'h05, 1'b1);
    check_done(0, "sub_03_05", 8, 8);
    start_op(0, 16'h80, 16'h01, 1'b1);
    check_done(0, "sub_80_01", 8, 8);
    start_op(0, 16'h5A, 16'h5A, 1'b1);
    check_done(0, "sub_5A_5A", 8, 8);
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    start_op(0, 16'h12, 16'h34, 1'b0);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 16'hFF, 16'hFF, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 16'hAA, 16'h55, 1'b1);
    check_done(0, "ignore_start", 5, 5);
    repeat (12) begin
      @(negedge clk);
      if (obs(0).done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL ignore_start_extra_done: got %0d want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    obs_t        o;
    logic [15:0] r1;
    logic        c1, v1;
    model(8, 16'h11, 16'h22, 1'b0, r1, c1, v1);
    start_op(0, 16'h11, 16'h22, 1'b0);
    check_done(0, "b2b_first", 8, 8);
    start_op(0, 16'h40, 16'h50, 1'b1);
    repeat (3) @(negedge clk);
    o = obs(0);
    checks++;
    if (o.res !== r1 || o.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: got res=%h busy=%b want res=%h busy=1", o.res, o.busy, r1);
    end
    check_done(0, "b2b_second", 5, 5);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   pulses = 0;
    start_op(0, 16'hC0, 16'h80, 1'b0);
    check_done(0, "pre_reset", 8, 8);
    start_op(0, 16'h10, 16'h20, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    o = obs(0);
    checks++;
    if (o.busy !== 1'b0 || o.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ctrl: got busy=%b done=%b want 0 0", o.busy, o.done);
    end
    checks++;
    if (o.res !== 16'h0 || o.cout !== 1'b0 || o.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got res=%h cout=%b ovf=%b want 0 0 0", o.res, o.cout, o.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (obs(0).done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d want 0", pulses);
    end
    start_op(0, 16'h21, 16'h13, 1'b0);
    check_done(0, "after_reset", 8, 8);
  endtask

  task automatic test_sweep();
    logic [15:0] ra, rb;
    logic        rm;
    int          order [4] = '{0, 1, 2, 3};
    start_op(1, 16'hFFFF, 16'h0001, 1'b0);
    check_done(1, "w16_b4_add", 4, 4);
    start_op(1, 16'h8000, 16'h0001, 1'b1);
    check_done(1, "w16_b4_sub", 4, 4);
    start_op(2, 16'h1234, 16'hF00F, 1'b0);
    check_done(2, "w16_b16_add", 1, 1);
    start_op(3, 16'h7, 16'h1, 1'b0);
    check_done(3, "w4_b2_add", 2, 2);
    foreach (order[k]) begin
      for (int j = 0; j < 6; j++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rm = 1'($urandom_range(0, 1));
        start_op(order[k], ra, rb, rm);
        check_done(order[k], $sformatf("rand_inst%0d_%0d", order[k], j), NL[order[k]], NL[order[k]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
